// File: rtl/param_fifo.sv
// Single-clock FIFO with selectable registered or first-word-fall-through read,
// occupancy level, programmable nearly_full/nearly_empty thresholds and sticky error flags.
module param_fifo #(
    parameter int data_width      = 16,
    parameter int depth           = 8,
    parameter int full_threshold  = 2,
    parameter int empty_threshold = 1,
    parameter bit fwft            = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [data_width-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [data_width-1:0]   rd_data,
    output logic                    rd_valid,
    output logic [$clog2(depth):0]  level,
    output logic                    empty,
    output logic                    nearly_empty,
    output logic                    nearly_full,
    output logic                    full,
    input  logic                    clear_errors,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int aw = $clog2(depth);
    localparam int lw = aw + 1;
    localparam logic [lw-1:0] full_level = lw'(depth);
    localparam logic [lw-1:0] nf_level   = lw'(depth - full_threshold);
    localparam logic [lw-1:0] ne_level   = lw'(empty_threshold);

    logic [data_width-1:0] mem [depth];
    logic [aw-1:0]         wr_ptr;
    logic [aw-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovf_set;
    logic                  udf_set;

    assign empty        = (level == '0);
    assign full         = (level == full_level);
    assign nearly_full  = (level >= nf_level);
    assign nearly_empty = (level <= ne_level);

    // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
    assign rd_acc  = rd_en & ~empty & ~flush;
    assign wr_acc  = wr_en & ~flush & (~full | rd_acc);
    assign ovf_set = wr_en & ~flush & ~wr_acc;
    assign udf_set = rd_en & empty & ~flush;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow & ~clear_errors);
            underflow <= udf_set | (underflow & ~clear_errors);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (wr_acc && !rd_acc) begin
                    level <= level + 1'b1;
                end else if (rd_acc && !wr_acc) begin
                    level <= level - 1'b1;
                end
            end
        end
    end

    // FWFT exposes the head straight from storage; registered mode captures it on each pop.
    generate
        if (fwft) begin : g_fwft
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = ~empty;
        end else begin : g_reg
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        rd_data <= mem[rd_ptr];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Drives a registered-read and an FWFT instance with identical stimulus and checks
// both against a queue-based reference model.
module tb_param_fifo;

    localparam int dw    = 16;
    localparam int depth = 8;
    localparam int fth   = 2;
    localparam int eth   = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [dw-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          clear_errors = 1'b0;

    logic [dw-1:0] r_rd_data, f_rd_data;
    logic          r_rd_valid, f_rd_valid;
    logic [3:0]    r_level, f_level;
    logic          r_empty, f_empty, r_nempty, f_nempty;
    logic          r_nfull, f_nfull, r_full, f_full;
    logic          r_ovf, f_ovf, r_udf, f_udf;

    int checks = 0;
    int errors = 0;

    logic [dw-1:0] q[$];
    logic [dw-1:0] m_rd_data = '0;
    logic          m_rd_valid = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    always #5 clk = ~clk;

    param_fifo #(.data_width(dw), .depth(depth), .full_threshold(fth),
                 .empty_threshold(eth), .fwft(1'b0)) u_reg (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(r_rd_data), .rd_valid(r_rd_valid), .level(r_level),
        .empty(r_empty), .nearly_empty(r_nempty), .nearly_full(r_nfull), .full(r_full),
        .clear_errors(clear_errors), .overflow(r_ovf), .underflow(r_udf));

    param_fifo #(.data_width(dw), .depth(depth), .full_threshold(fth),
                 .empty_threshold(eth), .fwft(1'b1)) u_fwft (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .level(f_level),
        .empty(f_empty), .nearly_empty(f_nempty), .nearly_full(f_nfull), .full(f_full),
        .clear_errors(clear_errors), .overflow(f_ovf), .underflow(f_udf));

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
    endtask

    // Reference: occupancy is the queue size, flags follow from the acceptance rules.
    task automatic model_step(input logic fl, input logic we, input logic [dw-1:0] wd,
                              input logic re, input logic ce);
        int  n;
        bit  racc, wacc;
        n    = q.size();
        racc = re && (n != 0) && !fl;
        wacc = we && !fl && ((n != depth) || racc);
        m_ovf = (we && !fl && !wacc) || (m_ovf && !ce);
        m_udf = (re && (n == 0) && !fl) || (m_udf && !ce);
        if (fl) begin
            q.delete();
            m_rd_valid = 1'b0;
        end else begin
            m_rd_valid = racc;
            if (racc) m_rd_data = q.pop_front();
            if (wacc) q.push_back(wd);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check_output({tag, ".level_r"}, 32'(r_level), 32'(n));
        check_output({tag, ".level_f"}, 32'(f_level), 32'(n));
        check_output({tag, ".empty"}, 32'({r_empty, f_empty}), {30'b0, {2{n == 0}}});
        check_output({tag, ".full"}, 32'({r_full, f_full}), {30'b0, {2{n == depth}}});
        check_output({tag, ".nfull"}, 32'({r_nfull, f_nfull}), {30'b0, {2{n >= depth - fth}}});
        check_output({tag, ".nempty"}, 32'({r_nempty, f_nempty}), {30'b0, {2{n <= eth}}});
        check_output({tag, ".ovf"}, 32'({r_ovf, f_ovf}), {30'b0, {2{m_ovf}}});
        check_output({tag, ".udf"}, 32'({r_udf, f_udf}), {30'b0, {2{m_udf}}});
        check_output({tag, ".rvalid_r"}, 32'(r_rd_valid), 32'(m_rd_valid));
        check_output({tag, ".rdata_r"}, 32'(r_rd_data), 32'(m_rd_data));
        check_output({tag, ".rvalid_f"}, 32'(f_rd_valid), 32'(n != 0));
        if (n != 0) check_output({tag, ".rdata_f"}, 32'(f_rd_data), 32'(q[0]));
    endtask

    // Inputs change on the falling edge; the model advances at the rising edge and
    // outputs are compared on the next falling edge.
    task automatic apply_stimulus(input string tag, input logic fl, input logic we,
                                  input logic [dw-1:0] wd, input logic re, input logic ce);
        flush = fl; wr_en = we; wr_data = wd; rd_en = re; clear_errors = ce;
        @(posedge clk);
        model_step(fl, we, wd, re, ce);
        @(negedge clk);
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clear_errors = 1'b0;
        check_all(tag);
    endtask

    task automatic check_async_reset(input string tag);
        check_output({tag, ".level"}, 32'({r_level, f_level}), 32'h0);
        check_output({tag, ".empty"}, 32'({r_empty, f_empty}), 32'h3);
        check_output({tag, ".valid"}, 32'({r_rd_valid, f_rd_valid}), 32'h0);
        check_output({tag, ".err"}, 32'({r_ovf, f_ovf, r_udf, f_udf}), 32'h0);
        check_output({tag, ".full"}, 32'({r_full, f_full, r_nfull, f_nfull}), 32'h0);
        check_output({tag, ".rdata_r"}, 32'(r_rd_data), 32'h0);
    endtask

    initial begin
        $display("[TB] param_fifo bench start");
        repeat (2) @(negedge clk);
        check_async_reset("reset");
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_all("post_reset");

        for (int i = 0; i < 4; i++) apply_stimulus("wr1000", 0, 1, dw'(16'h1000 + i), 0, 0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus("rd1000", 0, 0, '0, 1, 0);
            check_output("rd1000.const", 32'({r_rd_valid, r_rd_data}), 32'h10000 | (32'h1000 + i));
        end
        apply_stimulus("idle", 0, 0, '0, 0, 0);
        check_output("idle.valid_empty", 32'({r_rd_valid, r_empty}), 32'h1);

        for (int i = 0; i < 8; i++) apply_stimulus("fill2000", 0, 1, dw'(16'h2000 + i), 0, 0);
        check_output("fill.full_level", 32'({r_full, r_level}), 32'h18);
        apply_stimulus("wr_dead", 0, 1, 16'hDEAD, 0, 0);
        check_output("dead.ovf_level", 32'({r_ovf, r_level}), 32'h18);
        apply_stimulus("beef_rw", 0, 1, 16'hBEEF, 1, 0);
        check_output("beef.level_data", 32'({r_level, r_rd_data}), 32'h82000);
        for (int i = 0; i < 8; i++) apply_stimulus("drain", 0, 0, '0, 1, 0);
        check_output("drain.beef_last", 32'(r_rd_data), 32'hBEEF);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus("thresh_wr", 0, 1, dw'($urandom), 0, 0);
            if (i == 4) check_output("nfull_at5", 32'(r_nfull), 32'h0);
        end
        check_output("nfull_at6", 32'(r_nfull), 32'h1);
        for (int i = 0; i < 5; i++) apply_stimulus("thresh_rd", 0, 0, '0, 1, 0);
        check_output("nempty_at1", 32'({r_nempty, r_level}), 32'h11);
        apply_stimulus("flush_wr", 1, 1, 16'h3333, 0, 0);
        check_output("flush.state", 32'({r_empty, r_ovf, r_level}), 32'h30);
        apply_stimulus("clr_ovf", 0, 0, '0, 0, 1);

        apply_stimulus("wr5000", 0, 1, 16'h5000, 0, 0);
        check_output("fwft.head", 32'({f_rd_valid, f_rd_data}), 32'h15000);
        apply_stimulus("rd5000", 0, 0, '0, 1, 0);
        check_output("fwft.popped", 32'({f_rd_valid, f_empty}), 32'h1);

        apply_stimulus("udf1", 0, 0, '0, 1, 0);
        apply_stimulus("udf2", 0, 0, '0, 1, 0);
        check_output("udf.set_data", 32'({r_udf, r_rd_data}), 32'h15000);
        apply_stimulus("udf_set_clr", 0, 0, '0, 1, 1);
        check_output("udf.set_wins", 32'(r_udf), 32'h1);
        apply_stimulus("udf_clr", 0, 0, '0, 0, 1);
        check_output("udf.cleared", 32'(r_udf), 32'h0);

        for (int i = 0; i < 4; i++) apply_stimulus("wr6000", 0, 1, dw'(16'h6000 + i), 0, 0);
        for (int i = 0; i < 4; i++) apply_stimulus("rd6000", 0, 0, '0, 1, 0);
        for (int i = 0; i < 8; i++) apply_stimulus("wr7000", 0, 1, dw'(16'h7000 + i), 0, 0);
        check_output("wrap.full_head", 32'({f_full, f_rd_data}), 32'h17000);
        apply_stimulus("rd7000", 0, 0, '0, 1, 0);
        check_output("wrap.first_read", 32'(r_rd_data), 32'h7000);
        apply_stimulus("wr_mid", 0, 1, 16'h7777, 0, 0);
        #2 reset = 1'b0;
        #1 check_async_reset("mid_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all("after_mid_reset");

        for (int i = 0; i < 400; i++) begin
            apply_stimulus("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < 55),
                           dw'($urandom), ($urandom_range(0, 99) < 45),
                           ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
